// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: edge-detects the divider tick and the three buttons, runs the
// IDLE/RUNNING/PAUSED(/LAP) state machine and keeps a BCD mm:ss count with registered display.
// Optional lap feature is compiled in when the macro SW_LAP_EN is defined.
module stopwatch_ctrl (
    input  logic       sysClk,
    input  logic       reset,
    input  logic       div_clk,
    input  logic       btn_start,
    input  logic       btn_lap,
    input  logic       btn_clear,
    output logic       div_reset,
    output logic [3:0] sec_ones,
    output logic [2:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [2:0] min_tens,
    output logic       running,
    output logic       lap_active,
    output logic       overflow
);

`ifdef SW_LAP_EN
    typedef enum logic [1:0] {StIdle, StRunning, StPaused, StLap} state_t;
`else
    typedef enum logic [1:0] {StIdle, StRunning, StPaused} state_t;
`endif

    state_t      state_q, state_d;
    logic        div_q, start_q, clear_q;
    logic        tick, start_ev, clear_ev;
    logic        counting, inc, wrap, div_rst_d;
    // Internal count packed as {min_tens, min_ones, sec_tens, sec_ones}
    logic [13:0] cnt_q, cnt_d, disp_d;

    assign tick     = div_clk & ~div_q;
    assign start_ev = btn_start & ~start_q;
    assign clear_ev = btn_clear & ~clear_q;

`ifdef SW_LAP_EN
    logic        lap_q, lap_ev;
    logic [13:0] latch_q, latch_d;
    assign lap_ev   = btn_lap & ~lap_q;
    assign counting = (state_q == StRunning) || (state_q == StLap);
`else
    logic unused_lap;
    assign unused_lap = btn_lap;
    assign counting   = (state_q == StRunning);
    assign lap_active = 1'b0;
`endif

    // BCD increment of the internal count with carries and 59:59 wrap
    always_comb begin
        cnt_d = cnt_q;
        wrap  = 1'b0;
        inc   = tick & counting & ~clear_ev;
        if (clear_ev) begin
            cnt_d = '0;
        end else if (inc) begin
            if (cnt_q[3:0] == 4'd9) begin
                cnt_d[3:0] = 4'd0;
                if (cnt_q[6:4] == 3'd5) begin
                    cnt_d[6:4] = 3'd0;
                    if (cnt_q[10:7] == 4'd9) begin
                        cnt_d[10:7] = 4'd0;
                        if (cnt_q[13:11] == 3'd5) begin
                            cnt_d[13:11] = 3'd0;
                            wrap         = 1'b1;
                        end else begin
                            cnt_d[13:11] = cnt_q[13:11] + 3'd1;
                        end
                    end else begin
                        cnt_d[10:7] = cnt_q[10:7] + 4'd1;
                    end
                end else begin
                    cnt_d[6:4] = cnt_q[6:4] + 3'd1;
                end
            end else begin
                cnt_d[3:0] = cnt_q[3:0] + 4'd1;
            end
        end
    end

    // Next state with clear > start > lap priority, divider realignment and display select
    always_comb begin
        state_d   = state_q;
        div_rst_d = 1'b0;
        if (clear_ev) begin
            state_d   = StIdle;
            div_rst_d = 1'b1;
        end else if (start_ev) begin
            case (state_q)
                StIdle: begin
                    state_d   = StRunning;
                    div_rst_d = 1'b1;
                end
                StRunning: state_d = StPaused;
                StPaused:  state_d = StRunning;
`ifdef SW_LAP_EN
                StLap:     state_d = StPaused;
`endif
                default:   state_d = StIdle;
            endcase
`ifdef SW_LAP_EN
        end else if (lap_ev) begin
            if (state_q == StRunning) begin
                state_d = StLap;
            end else if (state_q == StLap) begin
                state_d = StRunning;
            end
`endif
        end
        disp_d = cnt_d;
`ifdef SW_LAP_EN
        latch_d = latch_q;
        if ((state_q != StLap) && (state_d == StLap)) begin
            latch_d = cnt_d;
        end
        if (state_d == StLap) begin
            disp_d = latch_d;
        end
`endif
    end

    // State, edge-detect flops and registered outputs; reset overrides every event
    always_ff @(posedge sysClk) begin
        if (reset) begin
            state_q   <= StIdle;
            div_q     <= 1'b1;
            start_q   <= 1'b1;
            clear_q   <= 1'b1;
            cnt_q     <= '0;
            div_reset <= 1'b0;
            running   <= 1'b0;
            overflow  <= 1'b0;
            {min_tens, min_ones, sec_tens, sec_ones} <= '0;
`ifdef SW_LAP_EN
            lap_q      <= 1'b1;
            latch_q    <= '0;
            lap_active <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            div_q     <= div_clk;
            start_q   <= btn_start;
            clear_q   <= btn_clear;
            cnt_q     <= cnt_d;
            div_reset <= div_rst_d;
            overflow  <= wrap;
            {min_tens, min_ones, sec_tens, sec_ones} <= disp_d;
`ifdef SW_LAP_EN
            lap_q      <= btn_lap;
            latch_q    <= latch_d;
            lap_active <= (state_d == StLap);
            running    <= (state_d == StRunning) || (state_d == StLap);
`else
            running    <= (state_d == StRunning);
`endif
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: a seconds-count model checked every cycle plus
// directed scenarios with literal expectations. Honours SW_LAP_EN like the design.
module tb_stopwatch_ctrl;

    logic       sysClk = 1'b0;
    logic       reset = 1'b1;
    logic       div_clk = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_lap = 1'b0;
    logic       btn_clear = 1'b0;
    logic       div_reset;
    logic [3:0] sec_ones;
    logic [2:0] sec_tens;
    logic [3:0] min_ones;
    logic [2:0] min_tens;
    logic       running;
    logic       lap_active;
    logic       overflow;

`ifdef SW_LAP_EN
    localparam bit LapEn = 1'b1;
`else
    localparam bit LapEn = 1'b0;
`endif

    stopwatch_ctrl dut (
        .sysClk    (sysClk),
        .reset     (reset),
        .div_clk   (div_clk),
        .btn_start (btn_start),
        .btn_lap   (btn_lap),
        .btn_clear (btn_clear),
        .div_reset (div_reset),
        .sec_ones  (sec_ones),
        .sec_tens  (sec_tens),
        .min_ones  (min_ones),
        .min_tens  (min_tens),
        .running   (running),
        .lap_active(lap_active),
        .overflow  (overflow)
    );

    always #5 sysClk = ~sysClk;

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Model: elapsed seconds as a plain integer, mode as 0 idle / 1 run / 2 pause / 3 lap
    int m_secs = 0, m_mode = 0, m_lapsecs = 0, m_disp = 0;
    bit m_run = 0, m_lapa = 0, m_ovf = 0, m_divr = 0, m_valid = 0;
    bit p_div = 1, p_start = 1, p_lap = 1, p_clear = 1;

    always @(posedge sysClk) begin : model
        int  secs, mode, lsecs;
        bit  ovf, divr, t, s, l, c;
        secs = m_secs; mode = m_mode; lsecs = m_lapsecs; ovf = 0; divr = 0;
        t = div_clk && !p_div; s = btn_start && !p_start;
        l = btn_lap && !p_lap && LapEn; c = btn_clear && !p_clear;
        if (reset) begin
            secs = 0; mode = 0; lsecs = 0;
            p_div <= 1; p_start <= 1; p_lap <= 1; p_clear <= 1;
        end else begin
            if (c) begin
                secs = 0; mode = 0; divr = 1;
            end else begin
                if (t && (mode == 1 || mode == 3)) begin
                    if (secs == 3599) begin secs = 0; ovf = 1; end
                    else secs = secs + 1;
                end
                if (s) begin
                    if (mode == 0) begin mode = 1; divr = 1; end
                    else if (mode == 1 || mode == 3) mode = 2;
                    else mode = 1;
                end else if (l) begin
                    if (mode == 1) begin mode = 3; lsecs = secs; end
                    else if (mode == 3) mode = 1;
                end
            end
            p_div <= div_clk; p_start <= btn_start; p_lap <= btn_lap; p_clear <= btn_clear;
        end
        m_secs <= secs; m_mode <= mode; m_lapsecs <= lsecs;
        m_disp <= (mode == 3) ? lsecs : secs;
        m_run <= (mode == 1 || mode == 3); m_lapa <= (mode == 3);
        m_ovf <= ovf; m_divr <= divr; m_valid <= 1'b1;
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge sysClk) begin
        logic [17:0] exp;
        if (m_valid) begin
            exp = {3'(m_disp / 600), 4'((m_disp / 60) % 10), 3'((m_disp % 60) / 10),
                   4'(m_disp % 10), m_run, m_lapa, m_ovf, m_divr};
            check("cycle", {14'b0, min_tens, min_ones, sec_tens, sec_ones,
                            running, lap_active, overflow, div_reset}, {14'b0, exp});
        end
    end

    task automatic step();
        @(posedge sysClk);
        #1;
    endtask

    task automatic do_tick(input int n);
        for (int i = 0; i < n; i++) begin
            div_clk = 1'b1; step();
            div_clk = 1'b0; step();
        end
    endtask

    task automatic press_start();
        btn_start = 1'b1; step();
        btn_start = 1'b0; step();
    endtask

    task automatic chk_disp(input string name, input logic [2:0] mt, input logic [3:0] mo,
                            input logic [2:0] st, input logic [3:0] so);
        check(name, {18'b0, min_tens, min_ones, sec_tens, sec_ones}, {18'b0, mt, mo, st, so});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        // Start button held through reset release must not count as a press
        btn_start = 1'b1;
        reset = 1'b1;
        repeat (3) step();
        check("reset_flags", {28'b0, running, lap_active, overflow, div_reset}, 32'h0);
        chk_disp("reset_disp", 3'd0, 4'd0, 3'd0, 4'd0);
        reset = 1'b0;
        repeat (3) step();
        check("held_start_idle", {30'b0, running, div_reset}, 32'h0);
        btn_start = 1'b0; step();

        // Start from idle pulses div_reset once, then three seconds counted
        btn_start = 1'b1; step();
        check("start_divrst", {30'b0, running, div_reset}, 32'h3);
        btn_start = 1'b0; step();
        check("divrst_one_cycle", {31'b0, div_reset}, 32'h0);
        do_tick(3);
        chk_disp("three_ticks", 3'd0, 4'd0, 3'd0, 4'd3);
        check("three_running", {31'b0, running}, 32'h1);

        // Clear + start + tick at 00:07 while running
        do_tick(4);
        chk_disp("at_seven", 3'd0, 4'd0, 3'd0, 4'd7);
        btn_start = 1'b1; btn_clear = 1'b1; div_clk = 1'b1; step();
        chk_disp("clear_combo_disp", 3'd0, 4'd0, 3'd0, 4'd0);
        check("clear_combo_flags", {30'b0, running, div_reset}, 32'h1);
        btn_start = 1'b0; btn_clear = 1'b0; div_clk = 1'b0; step();

        // Pause at 00:04, ignored ticks, resume without div_reset
        press_start();
        do_tick(4);
        btn_start = 1'b1; step();
        check("pause_running", {31'b0, running}, 32'h0);
        btn_start = 1'b0; step();
        do_tick(3);
        chk_disp("paused_hold", 3'd0, 4'd0, 3'd0, 4'd4);
        btn_start = 1'b1; step();
        check("resume_no_divrst", {30'b0, running, div_reset}, 32'h2);
        btn_start = 1'b0; step();
        do_tick(1);
        chk_disp("resume_count", 3'd0, 4'd0, 3'd0, 4'd5);

        // Lap at 00:10 (live display when the lap feature is compiled out)
        do_tick(5);
        chk_disp("at_ten", 3'd0, 4'd0, 3'd1, 4'd0);
        btn_lap = 1'b1; step();
        check("lap_enter", {31'b0, lap_active}, {31'b0, LapEn});
        btn_lap = 1'b0; step();
        do_tick(5);
        if (LapEn) chk_disp("lap_frozen", 3'd0, 4'd0, 3'd1, 4'd0);
        else chk_disp("lap_ignored", 3'd0, 4'd0, 3'd1, 4'd5);
        btn_lap = 1'b1; step();
        chk_disp("lap_exit_live", 3'd0, 4'd0, 3'd1, 4'd5);
        check("lap_exit_flags", {30'b0, running, lap_active}, 32'h2);
        btn_lap = 1'b0; step();

        // Start coinciding with a tick while running still counts
        btn_start = 1'b1; div_clk = 1'b1; step();
        chk_disp("start_tick_counts", 3'd0, 4'd0, 3'd1, 4'd6);
        check("start_tick_paused", {31'b0, running}, 32'h0);
        btn_start = 1'b0; div_clk = 1'b0; step();

        // Preload to 59:59 then wrap
        btn_clear = 1'b1; step();
        btn_clear = 1'b0; step();
        press_start();
        do_tick(3599);
        chk_disp("at_5959", 3'd5, 4'd9, 3'd5, 4'd9);
        div_clk = 1'b1; step();
        chk_disp("wrap_disp", 3'd0, 4'd0, 3'd0, 4'd0);
        check("wrap_flags", {30'b0, overflow, running}, 32'h3);
        div_clk = 1'b0; step();
        check("ovf_one_cycle", {30'b0, overflow, running}, 32'h1);
        do_tick(2);

        // Reset beats simultaneous start and tick
        reset = 1'b1; btn_start = 1'b1; div_clk = 1'b1; step();
        chk_disp("midreset_disp", 3'd0, 4'd0, 3'd0, 4'd0);
        check("midreset_flags", {28'b0, running, lap_active, overflow, div_reset}, 32'h0);
        btn_start = 1'b0; div_clk = 1'b0; step();
        reset = 1'b0; repeat (2) step();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameters SHALL be: none; all widths and limits are fixed by this document.
REQ-002 sysClk  in  1  system clock; all state changes occur on its rising edge.
REQ-003 reset  in  1  reset, synchronous, active-high.
REQ-004 div_clk  in  1  square-wave output of the frequency divider; one rising edge per counted second.
REQ-005 btn_start  in  1  debounced start/stop button, level.
REQ-006 btn_lap  in  1  debounced lap button, level.
REQ-007 btn_clear  in  1  debounced clear button, level.
REQ-008 div_reset  out  1  reset request to the divider, one-cycle pulse.
REQ-009 sec_ones  out  4  displayed seconds units, BCD 0-9.
REQ-010 sec_tens  out  3  displayed seconds tens, 0-5.
REQ-011 min_ones  out  4  displayed minutes units, BCD 0-9.
REQ-012 min_tens  out  3  displayed minutes tens, 0-5.
REQ-013 running  out  1  high in RUNNING and LAP states.
REQ-014 lap_active  out  1  high in LAP state (display frozen).
REQ-015 overflow  out  1  one-cycle pulse on 59:59 -> 00:00 wrap.

Function
REQ-016 Each level input SHALL have a registered previous-value flop. An event (tick, start, lap, clear) SHALL be true in the cycle where the input is 1 and its flop is 0.
REQ-017 The FSM SHALL have states IDLE, RUNNING, PAUSED and LAP.
REQ-018 Event priority SHALL be clear > start > lap when events coincide.
REQ-019 A clear in any state SHALL go to IDLE, zero the internal count and the display, and pulse div_reset for 1 cycle.
REQ-020 Transitions on start SHALL be:
- IDLE -> RUNNING, with a 1-cycle div_reset pulse to align the divider phase;
- RUNNING -> PAUSED;
- PAUSED -> RUNNING, with no div_reset;
- LAP -> PAUSED, with the display returning to live.
REQ-021 Transitions on lap SHALL be RUNNING -> LAP (display latched) and LAP -> RUNNING (display live). Lap SHALL be ignored in IDLE and PAUSED.
REQ-022 A tick SHALL increment the internal count only if the current (pre-edge) state is RUNNING or LAP. The updated value SHALL be visible one cycle after the tick cycle.
REQ-023 A tick coinciding with start from IDLE SHALL NOT count. A tick coinciding with start from RUNNING SHALL count. A tick coinciding with clear SHALL NOT count.
REQ-024 Counting SHALL be BCD with carries:
- sec_ones 9->0 carries to sec_tens;
- sec_tens 5->0 carries to min_ones;
- min_ones 9->0 carries to min_tens;
- 59:59 SHALL wrap to 00:00, pulse overflow for 1 cycle, and keep the state unchanged.
REQ-025 The display outputs SHALL equal the internal count, except in LAP, where they SHALL hold the value captured on the lap-entry edge while the internal count continues.
REQ-026 All outputs SHALL be registered.

Reset
REQ-027 On reset the block SHALL enter IDLE with all count and display outputs 0, and running, lap_active, overflow and div_reset at 0.
REQ-028 The edge-detect flops SHALL load 1 on reset, so that a button held through reset does not produce an event.
REQ-029 Reset asserted mid-count SHALL take priority over all events in the same cycle.

Configuration
REQ-030 Macro SW_LAP_EN SHALL control the lap feature.
- Defined: the LAP state, btn_lap handling and the display latch SHALL be compiled in as specified.
- Undefined: the LAP state and latch SHALL be absent, btn_lap SHALL be ignored, lap_active SHALL be tied 0, and the display SHALL always be live.

Verification
REQ-031 reset, then start pulse, then 3 div_clk rising edges -> div_reset 1 cycle after start; display 00:03; running=1.
REQ-032 Preload by 3599 ticks to 59:59, then 1 tick -> display 00:00; overflow high exactly 1 cycle; running remains 1.
REQ-033 (SW_LAP_EN) At 00:10, lap; 5 ticks; lap -> display holds 00:10 with lap_active=1, then shows 00:15 the cycle after the second lap.
REQ-034 start, clear and tick in the same cycle while RUNNING at 00:07 -> state IDLE; display 00:00; div_reset pulse; no increment.
REQ-035 btn_start held high through reset release -> no start event; state stays IDLE until the button is released and pressed again.
REQ-036 PAUSED at 00:04, 3 ticks, then start, then 1 tick -> display 00:04 while paused, then 00:05; no div_reset on resume.
